seq_detector_param: RTL

- Parametrised serial bit-pattern detector, the successor to the fixed 4-bit "1011" detector.
- Pattern, length (1..MAX_LEN) and overlap mode are runtime-programmable. Input bits are qualified by a valid strobe.
- Each match raises a registered one-cycle pulse and increments a saturating match counter.
- Sits on the serial data path after the bit-recovery logic; the count is read by the control/status block.

---
 rtl/seq_detector_param.sv | 132 +++++++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial bit-pattern detector.
//
// Shifts qualified serial bits into a history register. It flags a registered
// one-cycle pulse whenever the newest len bits equal the programmed pattern.
// Each match also bumps a saturating match counter.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   in_valid     qualifies din
//   din          serial data bit (newest bit lands in hist[0])
//   cfg_load     latch cfg_pattern / cfg_len / cfg_overlap, clear fill
//   cfg_pattern  pattern; bit [len-1] is received first, bit [0] last
//   cfg_len      pattern length, clamped to MAX_LEN; 0 disables matching
//   cfg_overlap  1 = overlapping matches, 0 = history restarts after a match
//   cnt_clear    clear match_count
//   detected     registered one-cycle match pulse
//   match_count  saturating match count
//   armed        registered (fill >= len && len != 0)
module seq_detector_param #(
   parameter int unsigned              MAX_LEN         = 8,
   parameter int unsigned              CNT_W           = 8,
   parameter logic [MAX_LEN-1:0]       DEFAULT_PATTERN = 8'b0000_1011,
   parameter int unsigned              DEFAULT_LEN     = 4,
   parameter bit                       DEFAULT_OVERLAP = 1'b1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic                         din,
   input  logic                         cfg_load,
   input  logic [MAX_LEN-1:0]           cfg_pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
   input  logic                         cfg_overlap,
   input  logic                         cnt_clear,
   output logic                         detected,
   output logic [CNT_W-1:0]             match_count,
   output logic                         armed
);

   localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
   localparam logic [LEN_W-1:0] LenMax = LEN_W'(MAX_LEN);
   localparam logic [LEN_W:0]   One    = (LEN_W + 1)'(1);

   logic [MAX_LEN-1:0] pattern_q, pattern_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               overlap_q, overlap_d;
   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic               detected_q, detected_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               armed_q, armed_d;

   logic [MAX_LEN-1:0] hist_next;
   logic [MAX_LEN-1:0] len_mask;
   logic               enough_bits;
   logic               match;

   // Match logic only sees registered history plus din; the result is registered
   // into detected_q, so there is no combinational din -> detected path.
   always_comb begin
      hist_next = {hist_q[MAX_LEN-2:0], din};
      len_mask  = '0;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
         len_mask[i] = (i < int'(len_q));
      end
      enough_bits = (({1'b0, fill_q} + One) >= {1'b0, len_q});
      // A load cycle never matches: its din is discarded.
      match = in_valid && !cfg_load && (len_q != '0) && enough_bits &&
              (((hist_next ^ pattern_q) & len_mask) == '0);
   end

   always_comb begin
      pattern_d  = pattern_q;
      len_d      = len_q;
      overlap_d  = overlap_q;
      hist_d     = hist_q;
      fill_d     = fill_q;
      detected_d = match;
      count_d    = count_q;

      if (cfg_load) begin
         pattern_d = cfg_pattern;
         len_d     = (cfg_len > LenMax) ? LenMax : cfg_len;
         overlap_d = cfg_overlap;
         fill_d    = '0;
      end else if (in_valid) begin
         hist_d = hist_next;
         if (match && !overlap_q) begin
            fill_d = '0;
         end else if (fill_q != LenMax) begin
            fill_d = fill_q + LEN_W'(1);
         end
      end

      // A clear that coincides with a match leaves that match counted.
      if (cnt_clear) begin
         count_d = match ? CNT_W'(1) : '0;
      end else if (match && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1);
      end

      armed_d = (fill_d >= len_d) && (len_d != '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pattern_q  <= DEFAULT_PATTERN;
         len_q      <= LEN_W'(DEFAULT_LEN);
         overlap_q  <= DEFAULT_OVERLAP;
         hist_q     <= '0;
         fill_q     <= '0;
         detected_q <= 1'b0;
         count_q    <= '0;
         armed_q    <= 1'b0;
      end else begin
         pattern_q  <= pattern_d;
         len_q      <= len_d;
         overlap_q  <= overlap_d;
         hist_q     <= hist_d;
         fill_q     <= fill_d;
         detected_q <= detected_d;
         count_q    <= count_d;
         armed_q    <= armed_d;
      end
   end

   assign detected    = detected_q;
   assign match_count = count_q;
   assign armed       = armed_q;

endmodule
